// File: rtl/alarm_pkg.sv
// Shared types and constants for the vehicle alarm controller: state encodings
// (also decoded by the display logic), default intervals and the lock FSM states.
package alarm_pkg;

  localparam int VALUE_W = 4;

  localparam logic [2:0] DBG_ARMED           = 3'd0;
  localparam logic [2:0] DBG_TRIGGERED       = 3'd1;
  localparam logic [2:0] DBG_SOUND           = 3'd2;
  localparam logic [2:0] DBG_DISARMED        = 3'd3;
  localparam logic [2:0] DBG_WAIT_DOOR_OPEN  = 3'd4;
  localparam logic [2:0] DBG_WAIT_DOOR_CLOSE = 3'd5;
  localparam logic [2:0] DBG_WAIT_ARM        = 3'd6;

  typedef enum logic [2:0] {
    ARMED           = DBG_ARMED,
    TRIGGERED       = DBG_TRIGGERED,
    SOUND           = DBG_SOUND,
    DISARMED        = DBG_DISARMED,
    WAIT_DOOR_OPEN  = DBG_WAIT_DOOR_OPEN,
    WAIT_DOOR_CLOSE = DBG_WAIT_DOOR_CLOSE,
    WAIT_ARM        = DBG_WAIT_ARM
  } alarm_state_e;

  typedef enum logic {
    LOCKED   = 1'b0,
    UNLOCKED = 1'b1
  } lock_state_e;

  localparam int unsigned T_ARM_DELAY_DEF       = 6;
  localparam int unsigned T_DRIVER_DELAY_DEF    = 8;
  localparam int unsigned T_PASSENGER_DELAY_DEF = 15;
  localparam int unsigned T_ALARM_ON_DEF        = 10;

  // Intervals wider than the timer load field are truncated, not saturated.
  function automatic logic [VALUE_W-1:0] to_interval(input int unsigned secs);
    return secs[VALUE_W-1:0];
  endfunction

endpackage

// File: rtl/alarm_fsm_if.sv
// Link between the alarm controller (master) and the countdown timer (slave).
interface alarm_fsm_if;
  import alarm_pkg::*;

  logic               start_timer;
  logic [VALUE_W-1:0] value;
  logic               expired;
  logic               half_hz_enable;

  modport master (output start_timer, value, input expired, half_hz_enable);
  modport slave  (input start_timer, value, output expired, half_hz_enable);

endinterface

// File: rtl/alarm_fsm_fuel_pump_lock.sv
// Fuel pump immobiliser: unlocks on hidden_switch + brake with the key on,
// relocks when the key goes off.
module fuel_pump_lock
  import alarm_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic ignition,
  input  logic hidden_switch,
  input  logic brake,
  output logic fuel_pump
);

  lock_state_e lock_q, lock_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) lock_q <= LOCKED;
    else        lock_q <= lock_d;
  end

  always_comb begin
    lock_d = lock_q;
    case (lock_q)
      LOCKED:   if (ignition && hidden_switch && brake) lock_d = UNLOCKED;
      UNLOCKED: if (!ignition) lock_d = LOCKED;
      default:  lock_d = LOCKED;
    endcase
  end

  assign fuel_pump = (lock_q == UNLOCKED);

endmodule

// File: rtl/alarm_fsm.sv
// Vehicle anti-theft controller. Optional immobiliser enabled by defining
// FUEL_PUMP_LOCK_EN; otherwise fuel_pump is the registered ignition.
module alarm_fsm
  import alarm_pkg::*;
#(
  parameter int unsigned T_ARM_DELAY       = T_ARM_DELAY_DEF,
  parameter int unsigned T_DRIVER_DELAY    = T_DRIVER_DELAY_DEF,
  parameter int unsigned T_PASSENGER_DELAY = T_PASSENGER_DELAY_DEF,
  parameter int unsigned T_ALARM_ON        = T_ALARM_ON_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ignition,
  input  logic        door_driver,
  input  logic        door_pass,
  input  logic        hidden_switch,
  input  logic        brake,
  alarm_fsm_if.master tmr,
  output logic        siren,
  output logic        status_led,
  output logic        fuel_pump,
  output logic [2:0]  state_dbg
);

  alarm_state_e       state_q, state_d;
  logic               start_q, start_d;
  logic [VALUE_W-1:0] value_q, value_d;
  logic               blank_q;
  logic               counting_q, counting_d;
  logic               siren_q, led_q, led_d;
  logic               doors_open, exp_qual;

  assign doors_open = door_driver | door_pass;
  // The timer needs a cycle to load, so expired is stale for two cycles after a load.
  assign exp_qual   = tmr.expired & ~start_q & ~blank_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ARMED;
      start_q    <= 1'b0;
      value_q    <= '0;
      blank_q    <= 1'b0;
      counting_q <= 1'b0;
      siren_q    <= 1'b0;
      led_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      value_q    <= value_d;
      blank_q    <= start_q;
      counting_q <= counting_d;
      siren_q    <= (state_d == SOUND);
      led_q      <= led_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    start_d    = 1'b0;
    value_d    = value_q;
    counting_d = counting_q;
    if (ignition) begin
      state_d    = DISARMED;
      counting_d = 1'b0;
    end else begin
      case (state_q)
        ARMED: begin
          if (door_driver) begin
            state_d = TRIGGERED;
            start_d = 1'b1;
            value_d = to_interval(T_DRIVER_DELAY);
          end else if (door_pass) begin
            state_d = TRIGGERED;
            start_d = 1'b1;
            value_d = to_interval(T_PASSENGER_DELAY);
          end
        end
        TRIGGERED: if (exp_qual) state_d = SOUND;
        SOUND: begin
          // counting_q marks a live hold-off countdown; a reopened door cancels it.
          if (doors_open) begin
            counting_d = 1'b0;
          end else if (!counting_q) begin
            start_d    = 1'b1;
            value_d    = to_interval(T_ALARM_ON);
            counting_d = 1'b1;
          end else if (exp_qual) begin
            state_d    = ARMED;
            counting_d = 1'b0;
          end
        end
        DISARMED:       state_d = WAIT_DOOR_OPEN;
        WAIT_DOOR_OPEN: if (door_driver) state_d = WAIT_DOOR_CLOSE;
        WAIT_DOOR_CLOSE: begin
          if (!doors_open) begin
            state_d = WAIT_ARM;
            start_d = 1'b1;
            value_d = to_interval(T_ARM_DELAY);
          end
        end
        WAIT_ARM: begin
          if (doors_open)    state_d = WAIT_DOOR_CLOSE;
          else if (exp_qual) state_d = ARMED;
        end
        default: state_d = ARMED;
      endcase
    end
  end

  always_comb begin
    led_d = 1'b0;
    case (state_d)
      ARMED:           led_d = tmr.half_hz_enable;
      TRIGGERED, SOUND: led_d = 1'b1;
      default:         led_d = 1'b0;
    endcase
  end

  assign tmr.start_timer = start_q;
  assign tmr.value       = value_q;
  assign siren           = siren_q;
  assign status_led      = led_q;
  assign state_dbg       = state_q;

`ifdef FUEL_PUMP_LOCK_EN
  fuel_pump_lock u_fuel_pump_lock (
    .clock         (clock),
    .reset         (reset),
    .ignition      (ignition),
    .hidden_switch (hidden_switch),
    .brake         (brake),
    .fuel_pump     (fuel_pump)
  );
`else
  logic fuel_q;
  logic unused_lock_inputs;

  assign unused_lock_inputs = hidden_switch ^ brake;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) fuel_q <= 1'b0;
    else        fuel_q <= ignition;
  end

  assign fuel_pump = fuel_q;
`endif

endmodule
